// File: rtl/div_unit.sv
// Multicycle signed 32-bit restoring divider for the CPU div instruction.
// Produces quotient on lo and remainder on hi, 33 cycles after an accepted start.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic [31:0] rem_sh;
  logic [32:0] trial;

  // R < |divisor| <= 2^31, so the shifted remainder always fits in 32 bits.
  assign rem_sh = {rem_q[30:0], quo_q[31]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_rem_d = neg_rem_q;
    neg_quo_d = neg_quo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == 32'd0) begin
            dz_d = 1'b1;
          end else begin
            neg_rem_d = dividend[31];
            neg_quo_d = dividend[31] ^ divisor[31];
            quo_d     = dividend[31] ? -dividend : dividend;
            dvs_d     = divisor[31] ? -divisor : divisor;
            rem_d     = 32'd0;
            cnt_d     = 5'd0;
            busy_d    = 1'b1;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_rem_q <= neg_rem_d;
      neg_quo_q <= neg_quo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
